axil_skid_slice: RTL and testbench

AXI4-Lite register slice inserted between the AXI-to-AXI-Lite converter output and the UART register slave (axiluart) to break combinational valid/ready and payload paths for timing closure. Each of the five channels (AW, W, B, AR, R) gets an independent 2-entry skid buffer. All outputs are registered, throughput is one beat per cycle per channel, and forward latency is 1 cycle. The slice is protocol-transparent: beats are never dropped, duplicated, reordered or modified.

---
 rtl/axil_skid_slice.sv | 199 +++++++++++++++++++
 tb/tb_axil_skid_slice.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_skid_slice.sv
// AXI4-Lite register slice: every channel passes through its own 2-entry skid buffer,
// so valid, ready and payload toward both sides come straight from flops.

module axil_skid_elem #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  logic             ready_r;
  logic             valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             push_s;
  logic             pop_s;

  assign push_s    = in_valid & ready_r;
  assign pop_s     = valid_r & out_ready;
  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_data  = out_data_r;

  // Occupancy state, registered flags and the output/skid payload registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_EMPTY;
      ready_r     <= 1'b0;
      valid_r     <= 1'b0;
      out_data_r  <= '0;
      skid_data_r <= '0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          // ready_r is low only on the first cycle after reset
          ready_r <= 1'b1;
          if (push_s) begin
            out_data_r <= in_data;
            valid_r    <= 1'b1;
            state_r    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push_s && !pop_s) begin
            skid_data_r <= in_data;
            ready_r     <= 1'b0;
            state_r     <= ST_TWO;
          end else if (push_s && pop_s) begin
            out_data_r <= in_data;
            ready_r    <= 1'b1;
          end else if (pop_s) begin
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_EMPTY;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            out_data_r <= skid_data_r;
            ready_r    <= 1'b1;
            state_r    <= ST_ONE;
          end else begin
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          ready_r <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

module axil_skid_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // slave side (from AXI-to-AXI-Lite converter)
  input  logic                    s_aw_valid,
  output logic                    s_aw_ready,
  input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
  input  logic [2:0]              s_aw_prot,
  input  logic                    s_w_valid,
  output logic                    s_w_ready,
  input  logic [DATA_WIDTH-1:0]   s_w_data,
  input  logic [DATA_WIDTH/8-1:0] s_w_strb,
  output logic                    s_b_valid,
  input  logic                    s_b_ready,
  output logic [1:0]              s_b_resp,
  input  logic                    s_ar_valid,
  output logic                    s_ar_ready,
  input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [2:0]              s_ar_prot,
  output logic                    s_r_valid,
  input  logic                    s_r_ready,
  output logic [DATA_WIDTH-1:0]   s_r_data,
  output logic [1:0]              s_r_resp,
  // master side (toward the register slave)
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [2:0]              m_aw_prot,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  input  logic [1:0]              m_b_resp,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [2:0]              m_ar_prot,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp
);

  localparam int AX_W = ADDR_WIDTH + 3;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int R_W  = DATA_WIDTH + 2;

  axil_skid_elem #(.WIDTH(AX_W)) u_aw (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (s_aw_valid),
    .in_ready (s_aw_ready),
    .in_data  ({s_aw_prot, s_aw_addr}),
    .out_valid(m_aw_valid),
    .out_ready(m_aw_ready),
    .out_data ({m_aw_prot, m_aw_addr})
  );

  axil_skid_elem #(.WIDTH(W_W)) u_w (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (s_w_valid),
    .in_ready (s_w_ready),
    .in_data  ({s_w_strb, s_w_data}),
    .out_valid(m_w_valid),
    .out_ready(m_w_ready),
    .out_data ({m_w_strb, m_w_data})
  );

  axil_skid_elem #(.WIDTH(2)) u_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (m_b_valid),
    .in_ready (m_b_ready),
    .in_data  (m_b_resp),
    .out_valid(s_b_valid),
    .out_ready(s_b_ready),
    .out_data (s_b_resp)
  );

  axil_skid_elem #(.WIDTH(AX_W)) u_ar (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (s_ar_valid),
    .in_ready (s_ar_ready),
    .in_data  ({s_ar_prot, s_ar_addr}),
    .out_valid(m_ar_valid),
    .out_ready(m_ar_ready),
    .out_data ({m_ar_prot, m_ar_addr})
  );

  axil_skid_elem #(.WIDTH(R_W)) u_r (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_valid (m_r_valid),
    .in_ready (m_r_ready),
    .in_data  ({m_r_resp, m_r_data}),
    .out_valid(s_r_valid),
    .out_ready(s_r_ready),
    .out_data ({s_r_resp, s_r_data})
  );

endmodule

// File: tb/tb_axil_skid_slice.sv
// Self-checking bench for axil_skid_slice: each channel is modelled as a FIFO of at
// most two beats whose ready flag is registered and held low through reset.
module tb_axil_skid_slice;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NCH = 5;  // 0 AW, 1 W, 2 B, 3 AR, 4 R

  logic          clk = 1'b0;
  logic          rst_i;
  logic          s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic [AW-1:0] s_aw_addr, m_aw_addr;
  logic [2:0]    s_aw_prot, m_aw_prot;
  logic          s_w_valid, s_w_ready, m_w_valid, m_w_ready;
  logic [DW-1:0] s_w_data, m_w_data;
  logic [3:0]    s_w_strb, m_w_strb;
  logic          s_b_valid, s_b_ready, m_b_valid, m_b_ready;
  logic [1:0]    s_b_resp, m_b_resp;
  logic          s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic [AW-1:0] s_ar_addr, m_ar_addr;
  logic [2:0]    s_ar_prot, m_ar_prot;
  logic          s_r_valid, s_r_ready, m_r_valid, m_r_ready;
  logic [DW-1:0] s_r_data, m_r_data;
  logic [1:0]    s_r_resp, m_r_resp;

  int checks = 0;
  int passes = 0;

  logic [63:0] mq [NCH][$];
  bit          rdy_ok;

  always #5 clk = ~clk;

  axil_skid_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp)
  );

  // Channel views: upstream side drives, downstream side observes
  function automatic logic in_valid_f(int ch);
    case (ch)
      0: in_valid_f = s_aw_valid;
      1: in_valid_f = s_w_valid;
      2: in_valid_f = m_b_valid;
      3: in_valid_f = s_ar_valid;
      4: in_valid_f = m_r_valid;
      default: in_valid_f = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] in_data_f(int ch);
    case (ch)
      0: in_data_f = 64'({s_aw_prot, s_aw_addr});
      1: in_data_f = 64'({s_w_strb, s_w_data});
      2: in_data_f = 64'(m_b_resp);
      3: in_data_f = 64'({s_ar_prot, s_ar_addr});
      4: in_data_f = 64'({m_r_resp, m_r_data});
      default: in_data_f = 64'd0;
    endcase
  endfunction

  function automatic logic out_ready_f(int ch);
    case (ch)
      0: out_ready_f = m_aw_ready;
      1: out_ready_f = m_w_ready;
      2: out_ready_f = s_b_ready;
      3: out_ready_f = m_ar_ready;
      4: out_ready_f = s_r_ready;
      default: out_ready_f = 1'b0;
    endcase
  endfunction

  function automatic logic obs_valid_f(int ch);
    case (ch)
      0: obs_valid_f = m_aw_valid;
      1: obs_valid_f = m_w_valid;
      2: obs_valid_f = s_b_valid;
      3: obs_valid_f = m_ar_valid;
      4: obs_valid_f = s_r_valid;
      default: obs_valid_f = 1'bx;
    endcase
  endfunction

  function automatic logic obs_ready_f(int ch);
    case (ch)
      0: obs_ready_f = s_aw_ready;
      1: obs_ready_f = s_w_ready;
      2: obs_ready_f = m_b_ready;
      3: obs_ready_f = s_ar_ready;
      4: obs_ready_f = m_r_ready;
      default: obs_ready_f = 1'bx;
    endcase
  endfunction

  function automatic logic [63:0] obs_data_f(int ch);
    case (ch)
      0: obs_data_f = 64'({m_aw_prot, m_aw_addr});
      1: obs_data_f = 64'({m_w_strb, m_w_data});
      2: obs_data_f = 64'(s_b_resp);
      3: obs_data_f = 64'({m_ar_prot, m_ar_addr});
      4: obs_data_f = 64'({s_r_resp, s_r_data});
      default: obs_data_f = 64'hx;
    endcase
  endfunction

  function automatic logic exp_valid_f(int ch);
    exp_valid_f = (mq[ch].size() > 0);
  endfunction

  function automatic logic exp_ready_f(int ch);
    exp_ready_f = rdy_ok && (mq[ch].size() < 2);
  endfunction

  // Advance one clock and update the FIFO model with the handshakes of that edge
  task automatic tick();
    bit do_push [NCH];
    bit do_pop  [NCH];
    logic [63:0] pdata [NCH];
    for (int ch = 0; ch < NCH; ch++) begin
      do_push[ch] = (in_valid_f(ch) === 1'b1) && exp_ready_f(ch);
      do_pop[ch]  = exp_valid_f(ch) && (out_ready_f(ch) === 1'b1);
      pdata[ch]   = in_data_f(ch);
    end
    @(posedge clk);
    if (rst_i) begin
      for (int ch = 0; ch < NCH; ch++) mq[ch].delete();
      rdy_ok = 1'b0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (do_pop[ch]) void'(mq[ch].pop_front());
        if (do_push[ch]) mq[ch].push_back(pdata[ch]);
      end
      rdy_ok = 1'b1;
    end
    #1;
  endtask

  task automatic set_out_ready(logic v);
    m_aw_ready = v; m_w_ready = v; s_b_ready = v; m_ar_ready = v; s_r_ready = v;
  endtask

  task automatic idle_in();
    s_aw_valid = 1'b0; s_w_valid = 1'b0; m_b_valid = 1'b0; s_ar_valid = 1'b0; m_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle_in();
    set_out_ready(1'b0);
    s_aw_addr = '0; s_aw_prot = '0; s_w_data = '0; s_w_strb = '0; m_b_resp = '0;
    s_ar_addr = '0; s_ar_prot = '0; m_r_data = '0; m_r_resp = '0;
    tick();
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs_valid_f(ch) !== 1'b0 || obs_ready_f(ch) !== 1'b0 || obs_data_f(ch) !== 64'd0) begin
        $display("FAIL reset_state ch%0d: valid/ready/data got %b/%b/%h want 0/0/0",
                 ch, obs_valid_f(ch), obs_ready_f(ch), obs_data_f(ch));
      end else passes++;
    end
    rst_i = 1'b0;
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs_valid_f(ch) !== 1'b0 || obs_ready_f(ch) !== 1'b1) begin
        $display("FAIL reset_release ch%0d: valid/ready got %b/%b want 0/1",
                 ch, obs_valid_f(ch), obs_ready_f(ch));
      end else passes++;
    end
  endtask

  task automatic test_single_write();
    set_out_ready(1'b1);
    idle_in();
    s_aw_valid = 1'b1; s_aw_addr = 32'h0000_0004; s_aw_prot = 3'd0;
    s_w_valid  = 1'b1; s_w_data  = 32'h0000_00A5; s_w_strb  = 4'h1;
    tick();
    idle_in();
    checks++;
    if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h0000_0004 || m_w_valid !== 1'b1 ||
        m_w_data !== 32'h0000_00A5 || m_w_strb !== 4'h1) begin
      $display("FAIL single_write: aw v/addr %b/%h w v/data/strb %b/%h/%h want 1/00000004 1/000000a5/1",
               m_aw_valid, m_aw_addr, m_w_valid, m_w_data, m_w_strb);
    end else passes++;
    checks++;
    if (s_aw_ready !== 1'b1 || s_w_ready !== 1'b1) begin
      $display("FAIL single_write_ready: aw/w ready got %b/%b want 1/1", s_aw_ready, s_w_ready);
    end else passes++;
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs_valid_f(ch) !== exp_valid_f(ch) || obs_ready_f(ch) !== exp_ready_f(ch)) begin
        $display("FAIL single_write_drain ch%0d: valid/ready got %b/%b want %b/%b",
                 ch, obs_valid_f(ch), obs_ready_f(ch), exp_valid_f(ch), exp_ready_f(ch));
      end else passes++;
    end
  endtask

  task automatic test_streaming_read();
    set_out_ready(1'b1);
    idle_in();
    for (int i = 0; i < 16; i++) begin
      s_ar_valid = 1'b1; s_ar_addr = 32'(i * 4); s_ar_prot = 3'($urandom_range(0, 7));
      m_r_valid  = 1'b1; m_r_data  = 32'h100 + 32'(i);
      m_r_resp   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
      tick();
      checks++;
      if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'(i * 4) || s_r_valid !== 1'b1 ||
          s_r_data !== 32'h100 + 32'(i)) begin
        $display("FAIL stream_beat%0d: ar v/addr %b/%h r v/data %b/%h want 1/%h 1/%h",
                 i, m_ar_valid, m_ar_addr, s_r_valid, s_r_data, 32'(i * 4), 32'h100 + 32'(i));
      end else passes++;
      for (int ch = 3; ch < NCH; ch++) begin
        checks++;
        if (obs_ready_f(ch) !== exp_ready_f(ch) || obs_data_f(ch) !== mq[ch][0]) begin
          $display("FAIL stream_model ch%0d: ready/data got %b/%h want %b/%h",
                   ch, obs_ready_f(ch), obs_data_f(ch), exp_ready_f(ch), mq[ch][0]);
        end else passes++;
      end
    end
    idle_in();
    tick();
    checks++;
    if (m_ar_valid !== 1'b0 || s_r_valid !== 1'b0) begin
      $display("FAIL stream_end: ar/r valid got %b/%b want 0/0", m_ar_valid, s_r_valid);
    end else passes++;
  endtask

  task automatic test_backpressure();
    logic [31:0] wv [3];
    logic [31:0] got [$];
    int idx = 0;
    int n = 0;
    wv[0] = 32'h11; wv[1] = 32'h22; wv[2] = 32'h33;
    set_out_ready(1'b1);
    m_w_ready = 1'b0;
    idle_in();
    for (int cyc = 0; cyc < 4; cyc++) begin
      s_w_valid = (idx < 3); s_w_data = wv[idx < 3 ? idx : 2]; s_w_strb = 4'hF;
      if (cyc >= 2) begin
        checks++;
        if (s_w_ready !== 1'b0) begin
          $display("FAIL bp_ready_low cyc%0d: s_w_ready got %b want 0", cyc, s_w_ready);
        end else passes++;
      end
      checks++;
      if (s_w_ready !== exp_ready_f(1) || m_w_valid !== exp_valid_f(1)) begin
        $display("FAIL bp_flags cyc%0d: ready/valid got %b/%b want %b/%b",
                 cyc, s_w_ready, m_w_valid, exp_ready_f(1), exp_valid_f(1));
      end else passes++;
      if (s_w_valid && exp_ready_f(1)) idx++;
      tick();
    end
    checks++;
    if (idx !== 2 || m_w_valid !== 1'b1 || m_w_data !== 32'h11) begin
      $display("FAIL bp_stall: accepted/valid/data got %0d/%b/%h want 2/1/00000011",
               idx, m_w_valid, m_w_data);
    end else passes++;
    m_w_ready = 1'b1;
    while (got.size() < 3 && n < 20) begin
      s_w_valid = (idx < 3); s_w_data = wv[idx < 3 ? idx : 2];
      if (m_w_valid === 1'b1) got.push_back(m_w_data);
      if (s_w_valid && exp_ready_f(1)) idx++;
      tick();
      n++;
    end
    idle_in();
    checks++;
    if (got.size() != 3) begin
      $display("FAIL bp_count: beats got %0d want 3", got.size());
    end else passes++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== wv[i]) begin
        $display("FAIL bp_order%0d: data got %h want %h", i, got[i], wv[i]);
      end else passes++;
    end
  endtask

  task automatic test_push_pop();
    logic [1:0] seq [3];
    logic [1:0] got [$];
    int idx = 0;
    int n = 0;
    seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b00;
    set_out_ready(1'b1);
    idle_in();
    while (got.size() < 3 && n < 30) begin
      m_b_valid = (idx < 3); m_b_resp = seq[idx < 3 ? idx : 2];
      s_b_ready = (n % 2 == 0);
      checks++;
      if (m_b_ready !== exp_ready_f(2) || s_b_valid !== exp_valid_f(2) ||
          (exp_valid_f(2) && s_b_resp !== mq[2][0][1:0])) begin
        $display("FAIL pushpop_model n%0d: ready/valid/resp got %b/%b/%b want %b/%b",
                 n, m_b_ready, s_b_valid, s_b_resp, exp_ready_f(2), exp_valid_f(2));
      end else passes++;
      if (s_b_valid === 1'b1 && s_b_ready) got.push_back(s_b_resp);
      if (m_b_valid && exp_ready_f(2)) idx++;
      tick();
      n++;
    end
    idle_in();
    s_b_ready = 1'b1;
    checks++;
    if (got.size() != 3) begin
      $display("FAIL pushpop_count: beats got %0d want 3", got.size());
    end else passes++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== seq[i]) begin
        $display("FAIL pushpop_resp%0d: resp got %b want %b", i, got[i], seq[i]);
      end else passes++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_out_ready(1'b1);
    m_ar_ready = 1'b0;
    idle_in();
    for (int i = 0; i < 3; i++) begin
      s_ar_valid = 1'b1; s_ar_addr = 32'hDEAD_0000 + 32'(i); s_ar_prot = 3'd1;
      tick();
    end
    checks++;
    if (s_ar_ready !== 1'b0 || m_ar_valid !== 1'b1 || m_ar_addr !== 32'hDEAD_0000) begin
      $display("FAIL rstmid_full: ready/valid/addr got %b/%b/%h want 0/1/dead0000",
               s_ar_ready, m_ar_valid, m_ar_addr);
    end else passes++;
    rst_i = 1'b1;
    s_ar_addr = 32'hBEEF_0000;
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs_valid_f(ch) !== 1'b0 || obs_ready_f(ch) !== 1'b0) begin
        $display("FAIL rstmid_in_reset ch%0d: valid/ready got %b/%b want 0/0",
                 ch, obs_valid_f(ch), obs_ready_f(ch));
      end else passes++;
    end
    rst_i = 1'b0;
    idle_in();
    m_ar_ready = 1'b1;
    tick();
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs_valid_f(ch) !== 1'b0 || obs_ready_f(ch) !== 1'b1) begin
        $display("FAIL rstmid_release ch%0d: valid/ready got %b/%b want 0/1",
                 ch, obs_valid_f(ch), obs_ready_f(ch));
      end else passes++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m_ar_valid !== 1'b0) begin
        $display("FAIL rstmid_stale%0d: m_ar_valid got %b want 0 (addr %h)", i, m_ar_valid, m_ar_addr);
      end else passes++;
    end
  endtask

  task automatic test_channel_indep();
    set_out_ready(1'b1);
    idle_in();
    s_w_valid = 1'b1; s_w_data = $urandom(); s_w_strb = 4'hC;
    tick();
    idle_in();
    checks++;
    if (m_w_valid !== 1'b1 || m_aw_valid !== 1'b0 || {m_w_strb, m_w_data} !== mq[1][0][35:0]) begin
      $display("FAIL indep_w: w/aw valid got %b/%b data %h want 1/0 %h",
               m_w_valid, m_aw_valid, m_w_data, mq[1][0][31:0]);
    end else passes++;
    tick();
    s_aw_valid = 1'b1; s_aw_addr = 32'h0000_0008; s_aw_prot = 3'd2;
    tick();
    idle_in();
    checks++;
    if (m_aw_valid !== 1'b1 || m_aw_addr !== 32'h0000_0008 || m_aw_prot !== 3'd2 || m_w_valid !== 1'b0) begin
      $display("FAIL indep_aw: aw v/addr/prot %b/%h/%0d w v %b want 1/00000008/2 0",
               m_aw_valid, m_aw_addr, m_aw_prot, m_w_valid);
    end else passes++;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      s_aw_valid = ($urandom_range(0, 3) != 0); s_aw_addr = $urandom(); s_aw_prot = 3'($urandom_range(0, 7));
      s_w_valid  = ($urandom_range(0, 3) != 0); s_w_data  = $urandom(); s_w_strb  = 4'($urandom_range(0, 15));
      m_b_valid  = ($urandom_range(0, 3) != 0); m_b_resp  = 2'($urandom_range(0, 3));
      s_ar_valid = ($urandom_range(0, 3) != 0); s_ar_addr = $urandom(); s_ar_prot = 3'($urandom_range(0, 7));
      m_r_valid  = ($urandom_range(0, 3) != 0); m_r_data  = $urandom(); m_r_resp  = 2'($urandom_range(0, 3));
      m_aw_ready = ($urandom_range(0, 1) != 0); m_w_ready = ($urandom_range(0, 2) != 0);
      s_b_ready  = ($urandom_range(0, 1) != 0); m_ar_ready = ($urandom_range(0, 2) != 0);
      s_r_ready  = ($urandom_range(0, 1) != 0);
      for (int ch = 0; ch < NCH; ch++) begin
        checks++;
        if (obs_valid_f(ch) !== exp_valid_f(ch) || obs_ready_f(ch) !== exp_ready_f(ch) ||
            (exp_valid_f(ch) && obs_data_f(ch) !== mq[ch][0])) begin
          $display("FAIL random n%0d ch%0d: valid/ready/data got %b/%b/%h want %b/%b/%h",
                   n, ch, obs_valid_f(ch), obs_ready_f(ch), obs_data_f(ch),
                   exp_valid_f(ch), exp_ready_f(ch), exp_valid_f(ch) ? mq[ch][0] : 64'd0);
        end else passes++;
      end
      tick();
    end
    idle_in();
    set_out_ready(1'b1);
    for (int n = 0; n < 3; n++) tick();
    for (int ch = 0; ch < NCH; ch++) begin
      checks++;
      if (obs_valid_f(ch) !== 1'b0 || obs_ready_f(ch) !== 1'b1 || mq[ch].size() != 0) begin
        $display("FAIL random_drain ch%0d: valid/ready got %b/%b want 0/1 (model depth %0d)",
                 ch, obs_valid_f(ch), obs_ready_f(ch), mq[ch].size());
      end else passes++;
    end
  endtask

  initial begin
    rdy_ok = 1'b0;
    test_reset();
    test_single_write();
    test_streaming_read();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_channel_indep();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
